// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off requests to NUM_VOICES gated voices with oldest-voice stealing and a guaranteed re-gate gap
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int FREQ_BITS = 4,
  parameter int RETRIG_CYCLES = 1024,
  parameter int AGE_BITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_on,
  input  logic [FREQ_BITS-1:0]            req_freq,
  output logic [NUM_VOICES-1:0]           voice_hold,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]           voice_active,
  output logic                            steal
);
  localparam int QW = $clog2(RETRIG_CYCLES + 1);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [QW-1:0] QMAX = QW'(RETRIG_CYCLES);
  localparam logic [AGE_BITS-1:0] AMAX = '1;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  state_t state_q, state_d;
  logic [NUM_VOICES-1:0] hold_q, hold_d, active_q, active_d;
  logic [NUM_VOICES-1:0][FREQ_BITS-1:0] freq_q, freq_d;
  logic [NUM_VOICES-1:0][QW-1:0] quiet_q, quiet_d;
  logic [NUM_VOICES-1:0][AGE_BITS-1:0] age_q, age_d;
  logic [IW-1:0] tgt_q, tgt_d, match_idx, old_idx, rf_idx, in_idx, pick;
  logic [FREQ_BITS-1:0] pend_q, pend_d;
  logic steal_q, steal_d;
  logic match_hit, old_hit, rf_hit, in_hit, pick_rf, is_steal, on_acc, off_acc, wait_done;
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    old_hit = 1'b0;
    old_idx = '0;
    rf_hit = 1'b0;
    rf_idx = '0;
    in_hit = 1'b0;
    in_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_q[i] && quiet_q[i] == QMAX) begin
        rf_hit = 1'b1;
        rf_idx = IW'(i);
      end
      if (!active_q[i]) begin
        in_hit = 1'b1;
        in_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (active_q[i] && freq_q[i] == req_freq && (!match_hit || age_q[i] > age_q[match_idx])) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (active_q[i] && (!old_hit || age_q[i] > age_q[old_idx])) begin
        old_hit = 1'b1;
        old_idx = IW'(i);
      end
    end
    pick = match_hit ? match_idx : rf_hit ? rf_idx : in_hit ? in_idx : old_idx;
    is_steal = !match_hit && !in_hit;
    pick_rf = !active_q[pick] && quiet_q[pick] == QMAX;
  end
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign on_acc = req_valid && req_ready && req_on;
  assign off_acc = req_valid && req_ready && !req_on;
  assign wait_done = state_q == ST_WAIT && quiet_q[tgt_q] == QMAX;
  always_ff @(posedge clk)
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (on_acc && !pick_rf) ? ST_WAIT : wait_done ? ST_IDLE : state_q;
  always_comb begin
    hold_d = hold_q;
    active_d = active_q;
    freq_d = freq_q;
    age_d = age_q;
    tgt_d = tgt_q;
    pend_d = pend_q;
    steal_d = on_acc && is_steal;
    for (int i = 0; i < NUM_VOICES; i++)
      quiet_d[i] = hold_q[i] ? '0 : (quiet_q[i] == QMAX ? QMAX : quiet_q[i] + 1'b1);
    if (on_acc) begin
      tgt_d = pick;
      pend_d = req_freq;
      for (int i = 0; i < NUM_VOICES; i++)
        if (active_q[i] && IW'(i) != pick && age_q[i] != AMAX) age_d[i] = age_q[i] + 1'b1;
      age_d[pick] = '0;
      hold_d[pick] = pick_rf;
      active_d[pick] = pick_rf;
      if (pick_rf) freq_d[pick] = req_freq;
    end
    if (off_acc && match_hit) begin
      hold_d[match_idx] = 1'b0;
      active_d[match_idx] = 1'b0;
      age_d[match_idx] = '0;
    end
    if (wait_done) begin
      hold_d[tgt_q] = 1'b1;
      active_d[tgt_q] = 1'b1;
      freq_d[tgt_q] = pend_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      active_q <= '0;
      freq_q <= '0;
      quiet_q <= {NUM_VOICES{QMAX}};
      age_q <= '0;
      tgt_q <= '0;
      pend_q <= '0;
      steal_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      active_q <= active_d;
      freq_q <= freq_d;
      quiet_q <= quiet_d;
      age_q <= age_d;
      tgt_q <= tgt_d;
      pend_q <= pend_d;
      steal_q <= steal_d;
    end
  end
  assign voice_hold = hold_q;
  assign voice_active = active_q;
  assign voice_freq = freq_q;
  assign steal = steal_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and randomized checks of voice_allocator against a timestamp-based behavioural model
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int FB = 4;
  localparam int R = 8;
  localparam int AB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_on = 1'b0;
  logic [FB-1:0] req_freq = '0;
  logic req_ready, steal;
  logic [NV-1:0] voice_hold, voice_active;
  logic [NV*FB-1:0] voice_freq;
  int n_chk = 0;
  int n_pass = 0;
  int m_hold[NV], m_freq[NV], m_act[NV], m_age[NV], m_fall[NV];
  int m_edge = 0;
  int m_tgt = 0;
  int m_pend = 0;
  bit m_wait = 0;
  bit m_steal = 0;
  always #5 clk = ~clk;
  voice_allocator #(.NUM_VOICES(NV), .FREQ_BITS(FB), .RETRIG_CYCLES(R), .AGE_BITS(AB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_on(req_on),
    .req_freq(req_freq), .voice_hold(voice_hold), .voice_freq(voice_freq),
    .voice_active(voice_active), .steal(steal)
  );
  function automatic int m_quiet(int v);
    int d = m_edge - m_fall[v];
    return m_hold[v] != 0 ? 0 : (d > R ? R : d);
  endfunction
  function automatic int m_best(bit use_f, int f);
    int b = -1;
    for (int v = 0; v < NV; v++)
      if (m_act[v] != 0 && (!use_f || m_freq[v] == f) && (b < 0 || m_age[v] > m_age[b])) b = v;
    return b;
  endfunction
  task automatic m_step(bit r, bit v, bit o, int f);
    int now = m_edge + 1;
    int t;
    bit free;
    bit st = 0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_hold[i] = 0; m_freq[i] = 0; m_act[i] = 0; m_age[i] = 0; m_fall[i] = now - R;
      end
      m_wait = 0;
    end else if (m_wait) begin
      if (m_quiet(m_tgt) == R) begin
        m_hold[m_tgt] = 1; m_act[m_tgt] = 1; m_freq[m_tgt] = m_pend; m_wait = 0;
      end
    end else if (v && o) begin
      t = m_best(1, f);
      if (t < 0) for (int i = NV - 1; i >= 0; i--) if (m_act[i] == 0 && m_quiet(i) == R) t = i;
      if (t < 0) for (int i = NV - 1; i >= 0; i--) if (m_act[i] == 0) t = i;
      if (t < 0) begin t = m_best(0, 0); st = 1; end
      free = m_act[t] == 0 && m_quiet(t) == R;
      for (int i = 0; i < NV; i++) if (i != t && m_act[i] != 0 && m_age[i] < (1 << AB) - 1) m_age[i]++;
      m_age[t] = 0;
      if (free) begin
        m_hold[t] = 1; m_act[t] = 1; m_freq[t] = f;
      end else begin
        if (m_hold[t] != 0) m_fall[t] = now;
        m_hold[t] = 0; m_act[t] = 0; m_wait = 1; m_tgt = t; m_pend = f;
      end
    end else if (v) begin
      t = m_best(1, f);
      if (t >= 0) begin
        if (m_hold[t] != 0) m_fall[t] = now;
        m_hold[t] = 0; m_act[t] = 0; m_age[t] = 0;
      end
    end
    m_steal = st;
    m_edge = now;
  endtask
  function automatic logic [NV-1:0] m_hv();
    logic [NV-1:0] x;
    for (int i = 0; i < NV; i++) x[i] = m_hold[i] != 0;
    return x;
  endfunction
  function automatic logic [NV-1:0] m_av();
    logic [NV-1:0] x;
    for (int i = 0; i < NV; i++) x[i] = m_act[i] != 0;
    return x;
  endfunction
  function automatic logic [NV*FB-1:0] m_fv();
    logic [NV*FB-1:0] x;
    int f;
    for (int i = 0; i < NV; i++) begin
      f = m_freq[i];
      x[i*FB +: FB] = f[FB-1:0];
    end
    return x;
  endfunction
  task automatic tick(bit r, bit v, bit o, int f);
    rst = r;
    req_valid = v;
    req_on = o;
    req_freq = FB'(f);
    @(posedge clk);
    m_step(r, v, o, f);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic fill4();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, 1, i);
      n_chk++; if (req_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", req_ready); else n_pass++;
    end
    n_chk++; if (voice_hold !== 4'b1111) $display("FAIL b2b_hold got %b exp 1111", voice_hold); else n_pass++;
  endtask
  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", req_ready); else n_pass++;
    n_chk++; if ({voice_hold, voice_active, voice_freq, steal} !== '0) $display("FAIL rst_outs got %b %b %h %b exp zeros", voice_hold, voice_active, voice_freq, steal); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else n_pass++;
  endtask
  task automatic test_immediate();
    tick(0, 1, 1, 5);
    n_chk++; if (voice_hold !== 4'b0001) $display("FAIL imm_hold got %b exp 0001", voice_hold); else n_pass++;
    n_chk++; if (voice_freq[3:0] !== 4'd5) $display("FAIL imm_freq got %0d exp 5", voice_freq[3:0]); else n_pass++;
    n_chk++; if (voice_active !== 4'b0001) $display("FAIL imm_active got %b exp 0001", voice_active); else n_pass++;
    n_chk++; if (steal !== 1'b0) $display("FAIL imm_steal got %b exp 0", steal); else n_pass++;
  endtask
  task automatic test_steal();
    int low = 1;
    int rlow = 1;
    fill4();
    tick(0, 1, 1, 9);
    n_chk++; if (steal !== 1'b1) $display("FAIL steal_pulse got %b exp 1", steal); else n_pass++;
    n_chk++; if (voice_hold !== 4'b1110 || req_ready !== 1'b0) $display("FAIL steal_gate got %b/%b exp 1110/0", voice_hold, req_ready); else n_pass++;
    for (int c = 0; c < 3 * R && voice_hold[0] === 1'b0; c++) begin
      tick(0, 0, 0, 0);
      if (voice_hold[0] === 1'b0) low++;
      if (req_ready === 1'b0) rlow++;
      n_chk++; if (voice_hold !== m_hv() || steal !== 1'b0) $display("FAIL steal_wait_hold got %b/%b exp %b/0", voice_hold, steal, m_hv()); else n_pass++;
    end
    n_chk++; if (low != R + 1) $display("FAIL steal_low_len got %0d exp %0d", low, R + 1); else n_pass++;
    n_chk++; if (rlow != R + 1) $display("FAIL steal_ready_len got %0d exp %0d", rlow, R + 1); else n_pass++;
    n_chk++; if (voice_hold !== 4'b1111 || voice_freq[3:0] !== 4'd9) $display("FAIL steal_regate got %b/%0d exp 1111/9", voice_hold, voice_freq[3:0]); else n_pass++;
    tick(0, 1, 1, 10);
    n_chk++; if (voice_hold !== 4'b1101 || steal !== 1'b1) $display("FAIL steal_oldest got %b/%b exp 1101/1", voice_hold, steal); else n_pass++;
  endtask
  task automatic test_note_off();
    fill4();
    tick(0, 1, 0, 2);
    n_chk++; if (voice_hold !== 4'b1101 || voice_active !== 4'b1101) $display("FAIL off_match got %b/%b exp 1101/1101", voice_hold, voice_active); else n_pass++;
    n_chk++; if (req_ready !== 1'b1 || voice_freq[7:4] !== 4'd2) $display("FAIL off_ready_freq got %b/%0d exp 1/2", req_ready, voice_freq[7:4]); else n_pass++;
    tick(0, 1, 0, 7);
    n_chk++; if ({voice_hold, voice_active, voice_freq} !== {4'b1101, 4'b1101, 16'h4321} || req_ready !== 1'b1) $display("FAIL off_nomatch got %b %b %h exp 1101 1101 4321", voice_hold, voice_active, voice_freq); else n_pass++;
  endtask
  task automatic test_free_wait();
    int low = 1;
    fill4();
    tick(0, 1, 0, 3);
    tick(0, 1, 1, 6);
    n_chk++; if (req_ready !== 1'b0 || steal !== 1'b0 || voice_hold !== 4'b1011) $display("FAIL fw_enter got %b/%b/%b exp 0/0/1011", req_ready, steal, voice_hold); else n_pass++;
    for (int c = 0; c < 3 * R && voice_hold[2] === 1'b0; c++) begin
      tick(0, 0, 0, 0);
      if (voice_hold[2] === 1'b0) low++;
    end
    n_chk++; if (low != R) $display("FAIL fw_low_len got %0d exp %0d", low, R); else n_pass++;
    n_chk++; if (voice_hold !== 4'b1111 || voice_freq[11:8] !== 4'd6) $display("FAIL fw_gate got %b/%0d exp 1111/6", voice_hold, voice_freq[11:8]); else n_pass++;
  endtask
  task automatic test_retrigger();
    int low = 1;
    fill4();
    tick(0, 1, 1, 3);
    n_chk++; if (steal !== 1'b0 || voice_hold !== 4'b1011) $display("FAIL rt_accept got %b/%b exp 0/1011", steal, voice_hold); else n_pass++;
    for (int c = 0; c < 3 * R && voice_hold[2] === 1'b0; c++) begin
      tick(0, 0, 0, 0);
      if (voice_hold[2] === 1'b0) low++;
    end
    n_chk++; if (low != R + 1) $display("FAIL rt_low_len got %0d exp %0d", low, R + 1); else n_pass++;
    n_chk++; if (voice_freq !== 16'h4321 || voice_hold !== 4'b1111) $display("FAIL rt_end got %h/%b exp 4321/1111", voice_freq, voice_hold); else n_pass++;
  endtask
  task automatic test_rst_wait();
    fill4();
    tick(0, 1, 1, 9);
    repeat (3) tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    n_chk++; if ({voice_hold, voice_active, voice_freq, steal, req_ready} !== '0) $display("FAIL rw_reset got %b %b %h %b %b exp zeros", voice_hold, voice_active, voice_freq, steal, req_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rw_ready got %b exp 1", req_ready); else n_pass++;
    tick(0, 1, 1, 4);
    n_chk++; if (voice_hold !== 4'b0001 || voice_freq !== 16'h0004) $display("FAIL rw_note got %b/%h exp 0001/0004", voice_hold, voice_freq); else n_pass++;
  endtask
  task automatic test_random();
    int bad = 0;
    tick(1, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
      tick(($urandom % 97) == 0, ($urandom % 2) == 0, ($urandom % 10) < 6, int'($urandom_range(0, 5)));
      n_chk++;
      if (voice_hold !== m_hv() || voice_active !== m_av() || voice_freq !== m_fv() || steal !== m_steal || req_ready !== (!m_wait && !rst)) begin
        if (bad++ < 10) $display("FAIL rand_cycle%0d got %b %b %h %b %b exp %b %b %h %b %b", c, voice_hold, voice_active, voice_freq, steal, req_ready, m_hv(), m_av(), m_fv(), m_steal, !m_wait && !rst);
      end else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_immediate();
    test_steal();
    test_note_off();
    test_free_wait();
    test_retrigger();
    test_rst_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
